nonce_tx_queue: RTL and testbench

- Buffers golden nonces produced by the hash-check stage and feeds them one word at a time to serial_transmit using its send/busy handshake.
- Replaces the direct golden_nonce/serial_send drive in the miner top, so nonces found while the UART is busy are queued instead of lost.
- Also carries the "nonce space exhausted" report, sent as the 32'h00000000 sentinel word.

---
 rtl/nonce_tx_queue_if.sv | 24 ++
 rtl/nonce_tx_queue.sv | 154 +++++++++++++++
 tb/tb_nonce_tx_queue.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/nonce_tx_queue_if.sv
// Handshake bundle between the hash-check stage, nonce_tx_queue and serial_transmit.
// The slave modport is the queue itself; the master side drives pushes and the UART busy flag.
interface nonce_tx_queue_if #(
    parameter int DEPTH_LOG2 = 3
);
    logic                  push;
    logic [31:0]           nonce_in;
    logic                  exhausted;
    logic                  tx_busy;
    logic                  tx_send;
    logic [31:0]           tx_word;
    logic [DEPTH_LOG2:0]   count;
    logic [15:0]           overflow_cnt;

    modport master (
        output push, nonce_in, exhausted, tx_busy,
        input  tx_send, tx_word, count, overflow_cnt
    );

    modport slave (
        input  push, nonce_in, exhausted, tx_busy,
        output tx_send, tx_word, count, overflow_cnt
    );
endinterface

// File: rtl/nonce_tx_queue.sv
// Queues golden nonces and the "nonce space exhausted" sentinel (32'h0) and hands them
// one at a time to serial_transmit over its send/busy handshake.
module nonce_tx_queue #(
    parameter int DEPTH_LOG2   = 3,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    nonce_tx_queue_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int TW    = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]         CNT_FULL = CW'(DEPTH);
    localparam logic [TW-1:0]         TMR_ONE  = TW'(1);
    localparam logic [TW-1:0]         TMR_LAST = TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_RISE = 2'd1,
        S_WAIT_FALL = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic [31:0]             mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic [15:0]             overflow_q, overflow_d;
    logic                    pending_q, pending_d;
    logic                    exh_q;
    logic                    tx_send_q, tx_send_d;
    logic [31:0]             tx_word_q, tx_word_d;
    logic                    pop_s, sentinel_s, full_s, push_ok_s, drop_s, rise_s;

    assign full_s    = (count_q == CNT_FULL);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push_ok_s = bus.push & (~full_s | pop_s);
    assign drop_s    = bus.push & full_s & ~pop_s;
    assign rise_s    = bus.exhausted & ~exh_q;

    // Issue FSM: next state, timer, send strobe and output word.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        tx_send_d  = 1'b0;
        tx_word_d  = tx_word_q;
        pop_s      = 1'b0;
        sentinel_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if ((count_q != '0) && !bus.tx_busy) begin
                    tx_word_d = mem_q[rd_ptr_q];
                    pop_s     = 1'b1;
                    tx_send_d = 1'b1;
                    state_d   = S_WAIT_RISE;
                end else if (pending_q && !bus.tx_busy) begin
                    tx_word_d  = 32'h0000_0000;
                    sentinel_s = 1'b1;
                    tx_send_d  = 1'b1;
                    state_d    = S_WAIT_RISE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_RISE: begin
                if (bus.tx_busy) begin
                    state_d = S_WAIT_FALL;
                end else if (timer_q == TMR_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end
            S_WAIT_FALL: begin
                if (!bus.tx_busy) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_FALL;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO bookkeeping, exhaust latch and overflow counter next-state.
    always_comb begin
        wr_ptr_d   = push_ok_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d   = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        // A fresh rising edge wins over the clear caused by issuing the sentinel.
        if (rise_s) begin
            pending_d = 1'b1;
        end else if (sentinel_s) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
        if (drop_s && (overflow_q != 16'hFFFF)) begin
            overflow_d = overflow_q + 16'd1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 16'd0;
            pending_q  <= 1'b0;
            exh_q      <= 1'b0;
            tx_send_q  <= 1'b0;
            tx_word_q  <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            pending_q  <= pending_d;
            exh_q      <= bus.exhausted;
            tx_send_q  <= tx_send_d;
            tx_word_q  <= tx_word_d;
        end
    end

    // Storage array; contents are invalidated by the pointer reset, not cleared.
    always_ff @(posedge clk) begin
        if (push_ok_s && !reset) begin
            mem_q[wr_ptr_q] <= bus.nonce_in;
        end
    end

    assign bus.tx_send      = tx_send_q;
    assign bus.tx_word      = tx_word_q;
    assign bus.count        = count_q;
    assign bus.overflow_cnt = overflow_q;
endmodule

// File: tb/tb_nonce_tx_queue.sv
// Directed bench for nonce_tx_queue: a transaction-level queue model checked every cycle,
// plus literal expectations for latency, timeout, overflow and reset behaviour.
module tb_nonce_tx_queue;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    nonce_tx_queue_if #(.DEPTH_LOG2(3)) bus ();

    nonce_tx_queue #(.DEPTH_LOG2(3), .BUSY_TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // UART stand-in: either forced, or busy for busy_len cycles after each send.
    logic busy_mode  = 1'b0;
    logic busy_force = 1'b0;
    int   busy_len   = 5;
    int   auto_cnt   = 0;
    assign bus.tx_busy = busy_mode ? (auto_cnt != 0) : busy_force;

    always @(negedge clk) begin
        if (busy_mode && bus.tx_send) auto_cnt <= busy_len;
        else if (auto_cnt != 0)       auto_cnt <= auto_cnt - 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Inputs as the DUT saw them at the last rising edge.
    logic s_reset, s_push, s_exh, s_busy;
    logic [31:0] s_nonce;
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        s_reset <= reset;
        s_push  <= bus.push;
        s_nonce <= bus.nonce_in;
        s_exh   <= bus.exhausted;
        s_busy  <= bus.tx_busy;
    end

    // Reference model: FIFO of accepted words, coalesced exhaust flag, drop counter.
    logic [31:0] fifo_m[$];
    logic [31:0] send_log[$];
    int          send_cyc_log[$];
    logic        pending_m  = 1'b0;
    logic        prev_exh_m = 1'b0;
    int          ovf_m      = 0;
    logic [31:0] word_m     = 32'h0;
    int          send_cnt   = 0;
    int          last_send_cyc = -100;

    always @(negedge clk) begin
        logic [31:0] exp_w;
        if (s_reset) begin
            fifo_m.delete();
            pending_m  = 1'b0;
            prev_exh_m = 1'b0;
            ovf_m      = 0;
            word_m     = 32'h0;
            check("reset_tx_send", {31'd0, bus.tx_send}, 32'd0);
        end else begin
            if (bus.tx_send) begin
                check("send_while_busy", {31'd0, s_busy}, 32'd0);
                check("send_spacing_ge3", {31'd0, (cyc - last_send_cyc) >= 3}, 32'd1);
                check("send_has_source", {31'd0, (fifo_m.size() != 0) || pending_m}, 32'd1);
                if (fifo_m.size() != 0) begin
                    exp_w = fifo_m.pop_front();
                end else begin
                    exp_w     = 32'h0;
                    pending_m = 1'b0;
                end
                word_m        = exp_w;
                last_send_cyc = cyc;
                send_cnt++;
                send_log.push_back(bus.tx_word);
                send_cyc_log.push_back(cyc);
            end
            if (s_exh && !prev_exh_m) pending_m = 1'b1;
            prev_exh_m = s_exh;
            if (s_push) begin
                if (fifo_m.size() < 8) fifo_m.push_back(s_nonce);
                else if (ovf_m < 65535) ovf_m++;
            end
        end
        check("tx_word", bus.tx_word, word_m);
        check("count", {28'd0, bus.count}, fifo_m.size());
        check("overflow_cnt", {16'd0, bus.overflow_cnt}, ovf_m);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        bus.push     = 1'b1;
        bus.nonce_in = w;
        step(1);
        bus.push     = 1'b0;
    endtask

    task automatic wait_sends(input int target, input int budget, input string name);
        for (int i = 0; i < budget && send_cnt < target; i++) step(1);
        check(name, {31'd0, send_cnt >= target}, 32'd1);
    endtask

    int base, n0, push_cyc;

    initial begin
        reset         = 1'b1;
        bus.push      = 1'b0;
        bus.nonce_in  = 32'h0;
        bus.exhausted = 1'b0;
        step(2);
        reset = 1'b0;
        check("rst_count", {28'd0, bus.count}, 32'd0);
        check("rst_tx_word", bus.tx_word, 32'h0);
        check("rst_overflow", {16'd0, bus.overflow_cnt}, 32'd0);
        step(2);

        // Single nonce, UART busy for 100 cycles.
        busy_mode = 1'b1; busy_len = 100;
        base = send_log.size();
        push_cyc = cyc;
        push_word(32'h1D4C8F3F);
        wait_sends(base + 1, 10, "t1_send_seen");
        check("t1_latency", last_send_cyc - push_cyc, 32'd2);
        step(110);
        check("t1_nsends", send_log.size() - base, 32'd1);
        check("t1_word", send_log[base], 32'h1D4C8F3F);
        check("t1_count", {28'd0, bus.count}, 32'd0);

        // Burst while busy, then release.
        busy_mode = 1'b0; busy_force = 1'b1; busy_len = 5;
        base = send_log.size();
        for (int i = 1; i <= 5; i++) push_word(i);
        check("t2_count", {28'd0, bus.count}, 32'd5);
        step(3);
        busy_mode = 1'b1;
        wait_sends(base + 5, 200, "t2_all_sent");
        step(20);
        check("t2_nsends", send_log.size() - base, 32'd5);
        for (int i = 0; i < 5; i++) check("t2_order", send_log[base + i], i + 1);
        check("t2_overflow", {16'd0, bus.overflow_cnt}, 32'd0);

        // Overflow: ten pushes into eight slots.
        busy_mode = 1'b0; busy_force = 1'b1;
        base = send_log.size();
        for (int i = 1; i <= 10; i++) push_word(i);
        step(1);
        check("t3_count_full", {28'd0, bus.count}, 32'd8);
        check("t3_overflow", {16'd0, bus.overflow_cnt}, 32'd2);
        busy_mode = 1'b1;
        wait_sends(base + 8, 300, "t3_all_sent");
        step(30);
        check("t3_nsends", send_log.size() - base, 32'd8);
        for (int i = 0; i < 8; i++) check("t3_order", send_log[base + i], i + 1);

        // Exhaust pulses coalesce behind a queued nonce.
        busy_mode = 1'b0; busy_force = 1'b1;
        base = send_log.size();
        push_word(32'hABCD0000);
        for (int i = 0; i < 3; i++) begin
            bus.exhausted = 1'b1; step(2);
            bus.exhausted = 1'b0; step(1);
        end
        busy_mode = 1'b1;
        wait_sends(base + 2, 100, "t4_sent");
        step(40);
        check("t4_nsends", send_log.size() - base, 32'd2);
        check("t4_first", send_log[base], 32'hABCD0000);
        check("t4_sentinel", send_log[base + 1], 32'h0);

        // Busy never rises: one send, timeout, no resend.
        busy_mode = 1'b0; busy_force = 1'b0;
        base = send_log.size();
        push_word(32'h12345678);
        wait_sends(base + 1, 10, "t5_send_seen");
        step(30);
        check("t5_nsends", send_log.size() - base, 32'd1);
        check("t5_word", send_log[base], 32'h12345678);
        check("t5_count", {28'd0, bus.count}, 32'd0);
        n0 = send_log.size();
        push_word(32'h9ABCDEF0);
        wait_sends(n0 + 1, 10, "t5b_first");
        push_word(32'h0F0F0F0F);
        wait_sends(n0 + 2, 40, "t5b_second");
        check("t5_timeout_gap", send_cyc_log[n0 + 1] - send_cyc_log[n0], 32'd17);
        step(40);
        check("t5_no_resend", send_log.size() - n0, 32'd2);

        // Reset while four entries wait behind a busy UART.
        busy_force = 1'b1;
        base = send_log.size();
        for (int i = 0; i < 4; i++) push_word(32'h60 + i);
        check("t6_count_pre", {28'd0, bus.count}, 32'd4);
        reset = 1'b1; step(1); reset = 1'b0;
        check("t6_count", {28'd0, bus.count}, 32'd0);
        check("t6_overflow", {16'd0, bus.overflow_cnt}, 32'd0);
        step(3);
        busy_force = 1'b0;
        step(30);
        check("t6_no_send", send_log.size() - base, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
